lpddr_resp_model: RTL and testbench
===================================

# lpddr_resp_model

Synthesizable single-clock responder for the mobile-DDR command bus. It is the memory-side end of the interface the controller in `bemicro_top` drives. It decodes ACT/RD/WR/PRE/REF/MRS/BST, tracks per-bank open rows and holds a small internal RAM. It returns read bursts at the programmed CAS latency and flags protocol violations. Data is exchanged at half rate: one 32-bit word per clock carries one rising-edge and one falling-edge 16-bit beat. This lets FPGA loopback builds and simulation benches run the controller without the vendor DDR model.

## Interface
Parameters:
- `ROW_W`, default 3: row bits retained internally; upper row bits are ignored.
- `COL_W`, default 5: word-column bits retained, taken from `a[COL_W:1]`.
- `MEM_AW`, default `2+ROW_W+COL_W`: RAM word-address width; fixed by the other two parameters.

Ports:
- `CLK_FPGA_50M`, in, 1: the single clock; all logic uses its rising edge.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `cke`, in, 1: clock enable. When low, every command is ignored.
- `cs_n`, `ras_n`, `cas_n`, `we_n`, in, 1 each: command strobes.
- `a`, in, 14: address, with A10 as the auto/all flag.
- `ba`, in, 2: bank address.
- `wdata`, in, 32: write word; `[15:0]` is the rising beat, `[31:16]` the falling beat.
- `wmask`, in, 4: byte masks; 1 = byte not written.
- `rdata`, out, 32: read word.
- `rvalid`, out, 1: high when `rdata` is valid.
- `err`, out, 1: one-cycle pulse on a protocol violation.
- `err_code`, out, 3: cause of the last violation; holds its value until the next one.

## Operation
Command decode:
- A command is decoded only when `cke`=1 and `cs_n`=0.
- `{ras_n,cas_n,we_n}` encoding: 011 ACT, 101 RD, 100 WR, 010 PRE, 001 REF, 000 MRS, 110 BST, 111 NOP.

Reset state:
- All banks closed.
- CL=3, BL=4.
- `rdata`=0, `rvalid`=0, `err`=0, `err_code`=0.
- Read and write bursts idle.

Command behaviour:
- ACT: opens `ba` with row `a[ROW_W-1:0]`.
- PRE: closes `ba`. With A10=1 it closes all banks. PRE to an already-closed bank is legal.
- RD/WR: start at column `a[COL_W:1]`. BL/2 words are accessed, wrapping inside the BL/2-aligned block.
- RD/WR with A10=1: the bank auto-closes after the burst.
- RAM word address is `{ba, row, col}`.
- MRS (ba=00) loads:
  - CL from `a[6:4]`; only 2 and 3 are legal.
  - BL from `a[2:0]`; 001 is BL2, 010 is BL4, 011 is BL8.
- MRS with ba≠00 (EMRS) is accepted and ignored.
- BST: terminates any read or write burst in progress. A read already in the CL pipeline is cancelled.
- REF: no-op when all banks are closed.

Errors (the command is ignored, `err` pulses, `err_code` updates):
- 1: RD/WR to a closed bank.
- 2: ACT to an open bank.
- 3: MRS or REF while any bank is open.
- 4: illegal CL/BL in MRS; the mode registers keep their previous values.

Collisions:
- A new RD during an active or pending read truncates the old burst. The new burst owns `rdata`.
- WR during a read cancels the remaining read words.
- RD during a write burst ends the write.
- PRE to the bank of an active burst truncates that burst at the same edge.

## Timing
- RD sampled at edge N: `rvalid`=1 after edges N+CL … N+CL+BL/2−1, with consecutive wrapped words. No bubbles inside a burst.
- Back-to-back RDs spaced BL/2 cycles apart give continuous `rvalid`.
- WR sampled at edge N: `wdata`/`wmask` are sampled at edges N+1 … N+BL/2. RAM is written at those edges.
- RD issued ≥1 cycle after the final write edge returns the new data.
- `err` is high for the single cycle after the offending edge.
- Mode changes take effect for commands issued after the MRS edge.
- `rst_n` low mid-burst: on the next edge, outputs return to reset values and the pipeline is flushed. RAM contents are unspecified.

## Structure
- `lpddr_resp_pkg` contains:
  - the command enum
  - error-code constants
  - reset CL/BL constants
  - the legal MRS field encodings
- Sub-module `lpddr_resp_bank_tbl`: 4-entry open/row tracker. It has a lookup port and an ACT/PRE/all-close update port.
- The top level holds:
  - the decode logic
  - the CL shift pipeline (depth 3) and burst counter
  - the write burst counter
  - the inferred RAM, 2^MEM_AW × 32, with byte enables

## Test plan
- Reset, then ACT b0 r2, WR col0 writing 0x11112222 and 0x33334444, then RD col0 → `rvalid` after edges N+3 and N+4 with those two words.
- MRS with CL=2 and BL=8, then ACT b1, RD col2 → 4 words starting at col2 and wrapping to col0 within the 4-word block; `rvalid` begins after edge N+2.
- RD to closed bank 3 → `err` pulse, `err_code`=1, no `rvalid`. ACT b0 twice → `err_code`=2.
- RD, then a second RD one cycle later to col4 → first burst cut to 1 word, then the col4 burst, all contiguous.
- WR with `wmask`=0b0101 over 0xFFFFFFFF → readback shows only bytes 1 and 3 updated. MRS with CL=5 → `err_code`=4 and CL stays unchanged.
- BST one cycle after RD issue → no `rvalid`. `rst_n` low during a burst → `rvalid`=0 on the next edge.

Source files
------------

// File: rtl/lpddr_resp_pkg.sv
// -----------------------------------------------------------------------------
// lpddr_resp_pkg
// Shared definitions for the mobile-DDR responder model: the command encoding
// seen on {ras_n,cas_n,we_n}, the error codes reported on err_code, the
// power-up mode-register values and the legal MRS field encodings.
// -----------------------------------------------------------------------------
package lpddr_resp_pkg;

  // {ras_n, cas_n, we_n} while cs_n is low and cke is high
  typedef enum logic [2:0] {
    CMD_MRS = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_BST = 3'b110,
    CMD_NOP = 3'b111
  } cmd_e;

  localparam logic [2:0] ERR_NONE        = 3'd0;
  localparam logic [2:0] ERR_BANK_CLOSED = 3'd1;  // RD/WR to a closed bank
  localparam logic [2:0] ERR_BANK_OPEN   = 3'd2;  // ACT to an open bank
  localparam logic [2:0] ERR_NOT_IDLE    = 3'd3;  // MRS/REF with a bank open
  localparam logic [2:0] ERR_BAD_MODE    = 3'd4;  // illegal CL or BL field

  // MRS a[6:4] (CAS latency) and a[2:0] (burst length) encodings
  localparam logic [2:0] MRS_CL2 = 3'd2;
  localparam logic [2:0] MRS_CL3 = 3'd3;
  localparam logic [2:0] MRS_BL2 = 3'b001;
  localparam logic [2:0] MRS_BL4 = 3'b010;
  localparam logic [2:0] MRS_BL8 = 3'b011;

  localparam logic [2:0] RESET_CL = MRS_CL3;
  localparam logic [2:0] RESET_BL = MRS_BL4;

  // Number of 32-bit words (two beats each) in one burst.
  function automatic logic [2:0] burst_words(input logic [2:0] bl_code);
    case (bl_code)
      MRS_BL2: return 3'd1;
      MRS_BL8: return 3'd4;
      default: return 3'd2;
    endcase
  endfunction

  function automatic logic mode_legal(input logic [2:0] cl_code,
                                      input logic [2:0] bl_code);
    return ((cl_code == MRS_CL2) || (cl_code == MRS_CL3)) &&
           ((bl_code == MRS_BL2) || (bl_code == MRS_BL4) || (bl_code == MRS_BL8));
  endfunction

endpackage

// File: rtl/lpddr_resp_bank_tbl.sv
// -----------------------------------------------------------------------------
// lpddr_resp_bank_tbl
// Four-entry open-bank / open-row tracker.
//   clk, rst_n          : clock, synchronous active-low reset (all banks closed)
//   lk_ba               : lookup bank
//   lk_open, lk_row     : lookup result (combinational)
//   any_open            : at least one bank is open
//   act_en/act_ba/act_row : open a bank with a row
//   close_mask          : one bit per bank to close (PRE, PRE-all, auto-close)
// -----------------------------------------------------------------------------
module lpddr_resp_bank_tbl #(
  parameter int ROW_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       lk_ba,
  output logic             lk_open,
  output logic [ROW_W-1:0] lk_row,
  output logic             any_open,
  input  logic             act_en,
  input  logic [1:0]       act_ba,
  input  logic [ROW_W-1:0] act_row,
  input  logic [3:0]       close_mask
);

  logic [3:0]       bank_open;
  logic [ROW_W-1:0] bank_row [4];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_open <= '0;
      for (int b = 0; b < 4; b++) bank_row[b] <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (close_mask[b]) bank_open[b] <= 1'b0;
        // ACT is only accepted for a closed bank, so it never competes with a close
        if (act_en && (act_ba == b[1:0])) begin
          bank_open[b] <= 1'b1;
          bank_row[b]  <= act_row;
        end
      end
    end
  end

  assign lk_open  = bank_open[lk_ba];
  assign lk_row   = bank_row[lk_ba];
  assign any_open = |bank_open;

endmodule

// File: rtl/lpddr_resp_model.sv
// -----------------------------------------------------------------------------
// lpddr_resp_model
// Memory-side responder for the mobile-DDR command bus at half rate: one
// 32-bit word per clock carries the rising beat [15:0] and falling beat [31:16].
//   CLK_FPGA_50M, rst_n        : clock, synchronous active-low reset
//   cke, cs_n, ras_n, cas_n, we_n, a, ba : command bus (A10 = auto/all flag)
//   wdata, wmask               : write word and byte masks (1 = keep byte)
//   rdata, rvalid              : read word at the programmed CAS latency
//   err, err_code              : one-cycle violation pulse and sticky cause
// Reads: word 0 enters the latency pipeline at the RD edge, later words are
// fed by a burst engine one per edge; the RAM is read from pipeline stage
// CL-1 and the registered output forms the final latency stage.
// -----------------------------------------------------------------------------
module lpddr_resp_model
  import lpddr_resp_pkg::*;
#(
  parameter int ROW_W  = 3,
  parameter int COL_W  = 5,
  parameter int MEM_AW = 2 + ROW_W + COL_W
) (
  input  logic        CLK_FPGA_50M,
  input  logic        rst_n,
  input  logic        cke,
  input  logic        cs_n,
  input  logic        ras_n,
  input  logic        cas_n,
  input  logic        we_n,
  input  logic [13:0] a,
  input  logic [1:0]  ba,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        err,
  output logic [2:0]  err_code
);

  // ---------------------------------------------------------------- decode
  cmd_e             cmd;
  logic             lk_open, any_open;
  logic [ROW_W-1:0] lk_row;
  logic [2:0]       cl_code, bl_code;
  logic [2:0]       words;
  logic [COL_W-1:0] mask, start_col;
  logic             rd_start, wr_start, act_en, pre_cmd, mrs_load, bst;
  logic             err_set;
  logic [2:0]       err_val;
  logic             unused_a;

  assign unused_a  = ^a;  // only some address bits carry meaning here
  assign words     = burst_words(bl_code);
  assign mask      = COL_W'(words - 3'd1);
  assign start_col = a[COL_W:1];

  function automatic logic [COL_W-1:0] next_col(input logic [COL_W-1:0] col,
                                                input logic [COL_W-1:0] blk);
    // advance inside the burst-aligned block, wrapping at its end
    return (col & ~blk) | ((col + COL_W'(1)) & blk);
  endfunction

  always_comb begin
    cmd = CMD_NOP;
    if (cke && !cs_n) cmd = cmd_e'({ras_n, cas_n, we_n});
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    rd_start = 1'b0;
    wr_start = 1'b0;
    act_en   = 1'b0;
    pre_cmd  = 1'b0;
    mrs_load = 1'b0;
    bst      = 1'b0;
    err_set  = 1'b0;
    err_val  = ERR_NONE;
    case (cmd)
      CMD_ACT: if (lk_open) begin err_set = 1'b1; err_val = ERR_BANK_OPEN; end
               else act_en = 1'b1;
      CMD_RD:  if (!lk_open) begin err_set = 1'b1; err_val = ERR_BANK_CLOSED; end
               else rd_start = 1'b1;
      CMD_WR:  if (!lk_open) begin err_set = 1'b1; err_val = ERR_BANK_CLOSED; end
               else wr_start = 1'b1;
      CMD_PRE: pre_cmd = 1'b1;
      CMD_MRS: begin
        if (any_open) begin
          err_set = 1'b1;
          err_val = ERR_NOT_IDLE;
        end else if (ba == 2'b00) begin
          if (mode_legal(a[6:4], a[2:0])) mrs_load = 1'b1;
          else begin err_set = 1'b1; err_val = ERR_BAD_MODE; end
        end
        // EMRS (ba != 0) is accepted and has no effect
      end
      CMD_REF: if (any_open) begin err_set = 1'b1; err_val = ERR_NOT_IDLE; end
      CMD_BST: bst = 1'b1;
      default: ;
    endcase
  end

  // ------------------------------------------------------------ burst state
  logic             rd_act, rd_auto, rd_cl3;
  logic [1:0]       rd_ba;
  logic [ROW_W-1:0] rd_row;
  logic [COL_W-1:0] rd_col, rd_mask;
  logic [2:0]       rd_left;   // engine words still to issue, including rd_col
  logic             wr_act, wr_auto;
  logic [1:0]       wr_ba;
  logic [ROW_W-1:0] wr_row;
  logic [COL_W-1:0] wr_col, wr_mask;
  logic [2:0]       wr_left;

  logic rd_stop, rd_flush, rd_eng_issue, rd_last;
  logic wr_stop, wr_do, wr_last;
  logic [3:0] close_mask;

  assign rd_stop  = bst || wr_start || (pre_cmd && (a[10] || ba == rd_ba));
  assign rd_flush = bst || wr_start;   // also drops words already in the CL pipe
  assign wr_stop  = bst || rd_start || (pre_cmd && (a[10] || ba == wr_ba));

  // A new RD takes this edge's pipeline slot, so the old engine word is dropped.
  assign rd_eng_issue = rd_act && !rd_stop && !rd_start;
  assign rd_last      = rd_eng_issue && (rd_left == 3'd1);
  assign wr_do        = wr_act && !wr_stop;
  assign wr_last      = wr_do && (wr_left == 3'd1);

  always_comb begin
    close_mask = 4'b0000;
    if (pre_cmd) close_mask = a[10] ? 4'b1111 : (4'b0001 << ba);
    if (rd_last && rd_auto) close_mask = close_mask | (4'b0001 << rd_ba);
    if (rd_start && a[10] && words == 3'd1) close_mask = close_mask | (4'b0001 << ba);
    if (wr_last && wr_auto) close_mask = close_mask | (4'b0001 << wr_ba);
  end

  lpddr_resp_bank_tbl #(.ROW_W(ROW_W)) u_bank_tbl (
    .clk        (CLK_FPGA_50M),
    .rst_n      (rst_n),
    .lk_ba      (ba),
    .lk_open    (lk_open),
    .lk_row     (lk_row),
    .any_open   (any_open),
    .act_en     (act_en),
    .act_ba     (ba),
    .act_row    (a[ROW_W-1:0]),
    .close_mask (close_mask)
  );

  // --------------------------------------------------------- CL pipeline
  logic              issue_vld, issue_cl3;
  logic [MEM_AW-1:0] issue_addr;
  logic [2:0]        pipe_vld, pipe_cl3;
  logic [MEM_AW-1:0] pipe_addr [3];
  logic              rd_fire;
  logic [MEM_AW-1:0] raddr, waddr;

  assign issue_vld  = rd_start || rd_eng_issue;
  assign issue_cl3  = rd_start ? (cl_code == MRS_CL3) : rd_cl3;
  assign issue_addr = rd_start ? MEM_AW'({ba, lk_row, start_col})
                               : MEM_AW'({rd_ba, rd_row, rd_col});
  assign waddr      = MEM_AW'({wr_ba, wr_row, wr_col});

  // Each word carries its own latency; CL2 words leave at stage 1, CL3 at stage 2.
  always_comb begin
    rd_fire = 1'b0;
    raddr   = pipe_addr[2];
    if (pipe_vld[1] && !pipe_cl3[1]) begin
      rd_fire = 1'b1;
      raddr   = pipe_addr[1];
    end else if (pipe_vld[2] && pipe_cl3[2]) begin
      rd_fire = 1'b1;
    end
  end

  always_ff @(posedge CLK_FPGA_50M) begin
    if (!rst_n) begin
      cl_code  <= RESET_CL;
      bl_code  <= RESET_BL;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      rd_act   <= 1'b0;
      rd_auto  <= 1'b0;
      rd_cl3   <= 1'b1;
      rd_ba    <= '0;
      rd_row   <= '0;
      rd_col   <= '0;
      rd_mask  <= '0;
      rd_left  <= '0;
      wr_act   <= 1'b0;
      wr_auto  <= 1'b0;
      wr_ba    <= '0;
      wr_row   <= '0;
      wr_col   <= '0;
      wr_mask  <= '0;
      wr_left  <= '0;
      pipe_vld <= '0;
      pipe_cl3 <= '0;
      for (int i = 0; i < 3; i++) pipe_addr[i] <= '0;
    end else begin
      if (mrs_load) begin
        cl_code <= a[6:4];
        bl_code <= a[2:0];
      end
      err <= err_set;
      if (err_set) err_code <= err_val;

      // read burst engine: holds the next word after word 0
      if (rd_start) begin
        rd_act  <= (words != 3'd1);
        rd_ba   <= ba;
        rd_row  <= lk_row;
        rd_col  <= next_col(start_col, mask);
        rd_mask <= mask;
        rd_left <= words - 3'd1;
        rd_auto <= a[10];
        rd_cl3  <= (cl_code == MRS_CL3);
      end else if (rd_act) begin
        if (rd_stop || rd_left == 3'd1) rd_act <= 1'b0;
        rd_col  <= next_col(rd_col, rd_mask);
        rd_left <= rd_left - 3'd1;
      end

      // write burst engine: data arrives on the edges after the WR edge
      if (wr_start) begin
        wr_act  <= 1'b1;
        wr_ba   <= ba;
        wr_row  <= lk_row;
        wr_col  <= start_col;
        wr_mask <= mask;
        wr_left <= words;
        wr_auto <= a[10];
      end else if (wr_act) begin
        if (wr_stop || wr_left == 3'd1) wr_act <= 1'b0;
        wr_col  <= next_col(wr_col, wr_mask);
        wr_left <= wr_left - 3'd1;
      end

      if (rd_flush) pipe_vld <= '0;
      else          pipe_vld <= {pipe_vld[1:0], issue_vld};
      pipe_cl3     <= {pipe_cl3[1:0], issue_cl3};
      pipe_addr[0] <= issue_addr;
      pipe_addr[1] <= pipe_addr[0];
      pipe_addr[2] <= pipe_addr[1];
    end
  end

  // ------------------------------------------------------------------ RAM
  logic [31:0] mem [2**MEM_AW];

  // NOTE: the RAM array has no reset so it maps onto block RAM; its contents
  // after reset are whatever was last written.
  always_ff @(posedge CLK_FPGA_50M) begin
    if (wr_do) begin
      for (int i = 0; i < 4; i++)
        if (!wmask[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  always_ff @(posedge CLK_FPGA_50M) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else if (rd_flush) begin
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_fire;
      if (rd_fire) rdata <= mem[raddr];
    end
  end

endmodule

// File: tb/tb_lpddr_resp_model.sv
// -----------------------------------------------------------------------------
// tb_lpddr_resp_model
// Directed stimulus for lpddr_resp_model. Issued reads push expected words
// with their due edge onto rd_q; violations push expected codes onto err_q.
// A negedge monitor pops and compares whenever rvalid or err is high.
// -----------------------------------------------------------------------------
module tb_lpddr_resp_model;
  import lpddr_resp_pkg::*;

  logic        CLK_FPGA_50M = 1'b0;
  logic        rst_n, cke, cs_n, ras_n, cas_n, we_n;
  logic [13:0] a;
  logic [1:0]  ba;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic [31:0] rdata;
  logic        rvalid, err;
  logic [2:0]  err_code;

  lpddr_resp_model dut (
    .CLK_FPGA_50M (CLK_FPGA_50M),
    .rst_n        (rst_n),
    .cke          (cke),
    .cs_n         (cs_n),
    .ras_n        (ras_n),
    .cas_n        (cas_n),
    .we_n         (we_n),
    .a            (a),
    .ba           (ba),
    .wdata        (wdata),
    .wmask        (wmask),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .err          (err),
    .err_code     (err_code)
  );

  always #5 CLK_FPGA_50M = ~CLK_FPGA_50M;

  int edge_cnt = 0;
  always @(posedge CLK_FPGA_50M) edge_cnt <= edge_cnt + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct { logic [31:0] data; int at; } rd_exp_t;
  typedef struct { logic [2:0]  code; int at; } err_exp_t;
  rd_exp_t  rd_q[$];
  err_exp_t err_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", name, got, want, edge_cnt);
    end
  endtask

  // ------------------------------------------------------------- monitor
  always @(negedge CLK_FPGA_50M) begin
    if (rvalid === 1'b1) begin
      if (rd_q.size() == 0) begin
        check("rvalid_unexpected", {31'b0, rvalid}, 32'd0);
      end else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        check("rdata", rdata, e.data);
        check("rdata_edge", 32'(edge_cnt), 32'(e.at));
      end
    end
    if (err === 1'b1) begin
      if (err_q.size() == 0) begin
        check("err_unexpected", {31'b0, err}, 32'd0);
      end else begin
        err_exp_t e;
        e = err_q.pop_front();
        check("err_code", {29'b0, err_code}, {29'b0, e.code});
        check("err_edge", 32'(edge_cnt), 32'(e.at));
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic issue(input logic [2:0] c, input logic [1:0] b,
                       input logic [13:0] addr, output int n);
    @(negedge CLK_FPGA_50M);
    cs_n = 1'b0;
    {ras_n, cas_n, we_n} = c;
    ba = b;
    a  = addr;
    @(posedge CLK_FPGA_50M);
    #1;
    n = edge_cnt;
    cs_n = 1'b1;
    {ras_n, cas_n, we_n} = CMD_NOP;
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge CLK_FPGA_50M);
    #1;
  endtask

  task automatic wr_burst(input logic [1:0] b, input int col, input int nw,
                          input logic [3:0][31:0] d, input logic [3:0][3:0] m);
    int n;
    issue(CMD_WR, b, 14'(col << 1), n);
    for (int i = 0; i < nw; i++) begin
      wdata = d[i];
      wmask = m[i];
      @(posedge CLK_FPGA_50M);
      #1;
    end
    wdata = '0;
    wmask = 4'hF;
  endtask

  task automatic exp_rd(input logic [31:0] d, input int at);
    rd_exp_t e;
    e.data = d;
    e.at   = at;
    rd_q.push_back(e);
  endtask

  task automatic exp_err(input logic [2:0] c, input int at);
    err_exp_t e;
    e.code = c;
    e.at   = at;
    err_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n2;
    rst_n = 1'b0; cke = 1'b1; cs_n = 1'b1;
    {ras_n, cas_n, we_n} = CMD_NOP;
    a = '0; ba = '0; wdata = '0; wmask = 4'hF;
    idle(3);
    check("reset_rdata", rdata, 32'h0);
    check("reset_rvalid", {31'b0, rvalid}, 32'd0);
    check("reset_err", {31'b0, err}, 32'd0);
    check("reset_err_code", {29'b0, err_code}, 32'd0);
    rst_n = 1'b1;
    idle(1);

    // CL3 BL4: write two words at bank 0 row 2 col 0, read them back
    issue(CMD_ACT, 2'd0, 14'd2, n);
    wr_burst(2'd0, 0, 2, {32'h0, 32'h0, 32'h33334444, 32'h11112222}, '0);
    issue(CMD_RD, 2'd0, 14'd0, n);
    exp_rd(32'h11112222, n + 3);
    exp_rd(32'h33334444, n + 4);
    idle(6);

    // RD then RD one cycle later: first burst cut to its first word
    wr_burst(2'd0, 4, 2, {32'h0, 32'h0, 32'hBBBB0005, 32'hAAAA0004}, '0);
    issue(CMD_RD, 2'd0, 14'd0, n);
    issue(CMD_RD, 2'd0, 14'(4 << 1), n2);
    exp_rd(32'h11112222, n + 3);
    exp_rd(32'hAAAA0004, n2 + 3);
    exp_rd(32'hBBBB0005, n2 + 4);
    idle(6);

    // protocol violations
    issue(CMD_RD, 2'd3, 14'd0, n);
    exp_err(ERR_BANK_CLOSED, n);
    idle(3);
    check("err_code_hold", {29'b0, err_code}, 32'd1);
    issue(CMD_ACT, 2'd0, 14'd2, n);
    exp_err(ERR_BANK_OPEN, n);
    idle(2);

    // byte masks: only bytes 1 and 3 of col 0 updated, col 1 fully masked
    wr_burst(2'd0, 0, 2, {32'h0, 32'h0, 32'h00000000, 32'hFFFFFFFF}, {4'h0, 4'h0, 4'hF, 4'b0101});
    issue(CMD_RD, 2'd0, 14'd0, n);
    exp_rd(32'hFF11FF22, n + 3);
    exp_rd(32'h33334444, n + 4);
    idle(6);

    // MRS with a bank open, then illegal CL=5 after closing all banks
    issue(CMD_MRS, 2'd0, 14'h023, n);
    exp_err(ERR_NOT_IDLE, n);
    idle(2);
    issue(CMD_PRE, 2'd0, 14'h400, n);
    issue(CMD_MRS, 2'd0, 14'h052, n);
    exp_err(ERR_BAD_MODE, n);
    idle(2);
    check("err_code_bad_mode", {29'b0, err_code}, 32'd4);

    // CL and BL must still be 3 and 4
    issue(CMD_ACT, 2'd0, 14'd2, n);
    issue(CMD_RD, 2'd0, 14'd0, n);
    exp_rd(32'hFF11FF22, n + 3);
    exp_rd(32'h33334444, n + 4);
    idle(6);
    issue(CMD_PRE, 2'd0, 14'h400, n);

    // CL2 BL8: four-word burst from col 2 wraps to col 0
    issue(CMD_MRS, 2'd0, 14'h023, n);
    issue(CMD_ACT, 2'd1, 14'd5, n);
    wr_burst(2'd1, 0, 4, {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0}, '0);
    issue(CMD_RD, 2'd1, 14'(2 << 1), n);
    exp_rd(32'hB2B2B2B2, n + 2);
    exp_rd(32'hB3B3B3B3, n + 3);
    exp_rd(32'hB0B0B0B0, n + 4);
    exp_rd(32'hB1B1B1B1, n + 5);
    idle(8);

    // BST one cycle after RD: nothing returned
    issue(CMD_RD, 2'd1, 14'd0, n);
    issue(CMD_BST, 2'd0, 14'd0, n);
    idle(8);

    // reset in the middle of a burst
    issue(CMD_RD, 2'd1, 14'd0, n);
    exp_rd(32'hB0B0B0B0, n + 2);
    exp_rd(32'hB1B1B1B1, n + 3);
    idle(3);
    rst_n = 1'b0;
    idle(1);
    check("rst_mid_rvalid", {31'b0, rvalid}, 32'd0);
    check("rst_mid_err_code", {29'b0, err_code}, 32'd0);
    rst_n = 1'b1;
    idle(6);

    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    check("err_q_drained", 32'(err_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
